// File: rtl/mem_bus_master.sv
// mem_bus_master: MEM-stage load/store bus master.
// Runs one single-beat req/ack transaction per load/store and stalls the pipeline
// until the aligned, extended result is ready for MEM/WB.
// Optional feature: define MEM_ALIGN_CHECK_EN to add misalign_o and suppress
// misaligned half/word accesses instead of treating them as aligned.
//
// state  | meaning
// S_IDLE | pass-through; a memory op stalls and captures the bus request
// S_BUS  | bus_req_o high, waiting for ack or the timeout limit
// S_DONE | one cycle, result (or error) presented to MEM/WB, stall released
module mem_bus_master #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        bus_err_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [3:0]    r_sel;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          r_err;

    logic          w_is_mem;
    logic          w_is_store;
    logic          w_signed;
    logic [1:0]    w_size;
    logic [3:0]    w_sel;
    logic [31:0]   w_wdata;
    logic          w_misalign;
    logic          w_start;
    logic          w_timeout;
    logic [7:0]    w_lane8;
    logic [15:0]   w_lane16;
    logic [31:0]   w_load;

    // Decode the EX/MEM aluop into access size, direction and signedness
    always_comb begin
        w_is_mem   = 1'b1;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = SZ_W;
        case (aluop_i)
            8'hE0: begin w_size = SZ_B; w_signed = 1'b1; end
            8'hE4: w_size = SZ_B;
            8'hE1: begin w_size = SZ_H; w_signed = 1'b1; end
            8'hE5: w_size = SZ_H;
            8'hE3: w_size = SZ_W;
            8'hE8: begin w_size = SZ_B; w_is_store = 1'b1; end
            8'hE9: begin w_size = SZ_H; w_is_store = 1'b1; end
            8'hEB: begin w_size = SZ_W; w_is_store = 1'b1; end
            default: w_is_mem = 1'b0;
        endcase
    end

    // Big-endian byte lanes and lane-replicated store data
    always_comb begin
        case (w_size)
            SZ_B: begin
                w_sel   = 4'b1000 >> mem_addr_i[1:0];
                w_wdata = {4{reg2_i[7:0]}};
            end
            SZ_H: begin
                w_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{reg2_i[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = reg2_i;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_is_mem &&
                        ((w_size == SZ_H && mem_addr_i[0]) ||
                         (w_size == SZ_W && mem_addr_i[1:0] != 2'b00));
    assign misalign_o = w_misalign && (r_state == S_IDLE);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start   = (r_state == S_IDLE) && w_is_mem && !w_misalign;
    assign w_timeout = (r_cnt == CNT_LAST) && !bus_ack_i;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Capture the request on start, count bus cycles, latch read data or error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_size   <= SZ_W;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_addr   <= {mem_addr_i[31:2], 2'b00};
                        r_sel    <= w_sel;
                        r_we     <= w_is_store;
                        r_wdata  <= w_is_store ? w_wdata : 32'h0;
                        r_size   <= w_size;
                        r_signed <= w_signed;
                        r_err    <= 1'b0;
                    end
                end
                S_BUS: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus_ack_i)      r_rdata <= bus_rdata_i;
                    else if (w_timeout) r_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Extract and extend the addressed lane(s) of the latched read data
    always_comb begin
        case (r_sel)
            4'b1000: w_lane8 = r_rdata[31:24];
            4'b0100: w_lane8 = r_rdata[23:16];
            4'b0010: w_lane8 = r_rdata[15:8];
            default: w_lane8 = r_rdata[7:0];
        endcase
        w_lane16 = r_sel[3] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_size)
            SZ_B:    w_load = r_signed ? {{24{w_lane8[7]}}, w_lane8} : {24'h0, w_lane8};
            SZ_H:    w_load = r_signed ? {{16{w_lane16[15]}}, w_lane16} : {16'h0, w_lane16};
            default: w_load = r_rdata;
        endcase
    end

    // Next state, stall and MEM/WB outputs
    always_comb begin
        w_next     = r_state;
        stallreq_o = 1'b0;
        bus_err_o  = 1'b0;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    wreg_o = 1'b0;
                    if (w_start) begin
                        w_next     = S_BUS;
                        stallreq_o = 1'b1;
                        wdata_o    = 32'h0;
                    end
                end
            end
            S_BUS: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
                wdata_o    = 32'h0;
                if (bus_ack_i || w_timeout) w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
                if (r_err || r_we) begin
                    bus_err_o = r_err;
                    wreg_o    = 1'b0;
                    wdata_o   = 32'h0;
                end else begin
                    wdata_o = w_load;
                end
            end
        endcase
    end

    assign bus_req_o   = (r_state == S_BUS);
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;

endmodule
